// File: rtl/game_input_pkg.sv
// Shared definitions for the board-input front end and the game top.
package game_input_pkg;

  // System clock shared with the game top.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Debounce window in milliseconds; 10 ms is long enough for typical tactile switches.
  localparam int unsigned DEBOUNCE_MS = 10;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 16;

  localparam int unsigned NUM_KEYS = 3;

  // Index of each key in the per-key vectors.
  typedef enum logic [1:0] {
    KEY_LEFT    = 2'd0,
    KEY_RIGHT   = 2'd1,
    KEY_RESTART = 2'd2
  } key_idx_e;

  // Reset sequencer states.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

  // Most recently pressed direction.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: polarity fix, 2-flop synchroniser, debounce counter, stable level and press pulse.
module key_debouncer
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,       // asynchronous, active low
  input  logic i_raw,
  output logic o_stable,
  output logic o_press
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_pressed;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Internal "pressed" is always 1 regardless of pin polarity.
  assign w_pressed = ACTIVE_LOW ? ~i_raw : i_raw;

  // Two-flop synchroniser; reset loads the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_pressed;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the stable level only after DEBOUNCE_CYCLES consecutive mismatches; any match restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        // Pulse only when the new level is "pressed"; releases are silent.
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: debounces the three keys, arbitrates left/right and sequences game_rst.
module input_conditioner
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES,
  parameter int unsigned KEYS_ACTIVE_LOW   = 1,
  parameter int unsigned LAST_PRESSED_WINS = 1
) (
  input  logic clk,
  input  logic rst,              // asynchronous, active low
  input  logic key_left_raw,
  input  logic key_right_raw,
  input  logic key_restart_raw,
  output logic button_left,
  output logic button_right,
  output logic left_pressed,
  output logic right_pressed,
  output logic game_rst
);

  localparam int unsigned   HCW       = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(RESET_HOLD_CYCLES - 1);
  localparam bit            ACT_LOW   = (KEYS_ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] w_press;
  logic                w_stable_left;
  logic                w_stable_right;
  logic                w_unused_restart_level;

  dir_e                w_last_dir_next;
  logic                w_lvl_left;
  logic                w_lvl_right;

  dir_e                r_last_dir;
  logic                r_button_left;
  logic                r_button_right;
  logic                r_left_pressed;
  logic                r_right_pressed;

  rst_state_e          r_state;
  logic [HCW-1:0]      r_hold_cnt;
  logic                r_game_rst;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACT_LOW)
  ) u_deb_left (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (key_left_raw),
    .o_stable (w_stable_left),
    .o_press  (w_press[KEY_LEFT])
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACT_LOW)
  ) u_deb_right (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (key_right_raw),
    .o_stable (w_stable_right),
    .o_press  (w_press[KEY_RIGHT])
  );

  // Only the press pulse of restart matters; its level is not consumed.
  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACT_LOW)
  ) u_deb_restart (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (key_restart_raw),
    .o_stable (w_unused_restart_level),
    .o_press  (w_press[KEY_RESTART])
  );

  // Resolve the direction pair; same-cycle presses go to right.
  always_comb begin
    w_last_dir_next = r_last_dir;
    if (w_press[KEY_RIGHT]) begin
      w_last_dir_next = DIR_RIGHT;
    end else if (w_press[KEY_LEFT]) begin
      w_last_dir_next = DIR_LEFT;
    end

    w_lvl_left  = w_stable_left;
    w_lvl_right = w_stable_right;
    if (w_stable_left && w_stable_right) begin
      if (LAST_PRESSED_WINS != 0) begin
        w_lvl_left  = (w_last_dir_next == DIR_LEFT);
        w_lvl_right = (w_last_dir_next == DIR_RIGHT);
      end else begin
        w_lvl_left  = 1'b0;
        w_lvl_right = 1'b0;
      end
    end
  end

  // Register the arbitrated outputs; game_rst masks them but last_dir keeps tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dir      <= DIR_LEFT;
      r_button_left   <= 1'b0;
      r_button_right  <= 1'b0;
      r_left_pressed  <= 1'b0;
      r_right_pressed <= 1'b0;
    end else begin
      r_last_dir      <= w_last_dir_next;
      r_button_left   <= w_lvl_left  & ~r_game_rst;
      r_button_right  <= w_lvl_right & ~r_game_rst;
      r_left_pressed  <= w_press[KEY_LEFT]  & ~r_game_rst;
      r_right_pressed <= w_press[KEY_RIGHT] & ~r_game_rst;
    end
  end

  // Reset sequencer: hold game_rst for RESET_HOLD_CYCLES after board reset or a restart press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HOLD;
      r_hold_cnt <= HOLD_LOAD;
      r_game_rst <= 1'b1;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_press[KEY_RESTART]) begin
            r_hold_cnt <= HOLD_LOAD;
          end else if (r_hold_cnt == '0) begin
            r_state    <= RUN;
            r_game_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HCW'(1);
          end
        end
        RUN: begin
          if (w_press[KEY_RESTART]) begin
            r_state    <= HOLD;
            r_hold_cnt <= HOLD_LOAD;
            r_game_rst <= 1'b1;
          end
        end
        default: begin
          r_state    <= HOLD;
          r_hold_cnt <= HOLD_LOAD;
          r_game_rst <= 1'b1;
        end
      endcase
    end
  end

  assign button_left   = r_button_left;
  assign button_right  = r_button_right;
  assign left_pressed  = r_left_pressed;
  assign right_pressed = r_right_pressed;
  assign game_rst      = r_game_rst;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based behavioural model plus directed literal checks.
module tb_input_conditioner;

  localparam int unsigned DC = 8;
  localparam int unsigned RH = 4;

  logic       clk;
  logic       rst;
  logic [2:0] raw_keys;   // [0]=left [1]=right [2]=restart, active low

  logic bl_a, br_a, lp_a, rp_a, gr_a;
  logic bl_b, br_b, lp_b, rp_b, gr_b;

  input_conditioner #(
    .DEBOUNCE_CYCLES   (DC),
    .RESET_HOLD_CYCLES (RH),
    .KEYS_ACTIVE_LOW   (1),
    .LAST_PRESSED_WINS (1)
  ) dut_a (
    .clk             (clk),
    .rst             (rst),
    .key_left_raw    (raw_keys[0]),
    .key_right_raw   (raw_keys[1]),
    .key_restart_raw (raw_keys[2]),
    .button_left     (bl_a),
    .button_right    (br_a),
    .left_pressed    (lp_a),
    .right_pressed   (rp_a),
    .game_rst        (gr_a)
  );

  input_conditioner #(
    .DEBOUNCE_CYCLES   (DC),
    .RESET_HOLD_CYCLES (RH),
    .KEYS_ACTIVE_LOW   (1),
    .LAST_PRESSED_WINS (0)
  ) dut_b (
    .clk             (clk),
    .rst             (rst),
    .key_left_raw    (raw_keys[0]),
    .key_right_raw   (raw_keys[1]),
    .key_restart_raw (raw_keys[2]),
    .button_left     (bl_b),
    .button_right    (br_b),
    .left_pressed    (lp_b),
    .right_pressed   (rp_b),
    .game_rst        (gr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: pressed samples per edge since reset, stable levels, pending pulses.
  logic [2:0] hist[$];
  logic [2:0] m_st;
  logic [2:0] m_pl;
  int         m_hold;
  logic       m_gr;
  logic       m_last_right;
  logic       e_bl_a, e_br_a, e_bl_b, e_br_b, e_lp, e_rp, e_gr;

  task automatic cmp_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_st = '0;
    m_pl = '0;
    m_hold = RH;
    m_gr = 1'b1;
    m_last_right = 1'b0;
    e_bl_a = 1'b0; e_br_a = 1'b0; e_bl_b = 1'b0; e_br_b = 1'b0;
    e_lp = 1'b0; e_rp = 1'b0; e_gr = 1'b1;
  endtask

  // Value the synchroniser presents at edge e: the pin sampled two edges earlier, else released.
  function automatic logic sync_at(input int e, input int k);
    logic [2:0] s;
    if (e < 2) return 1'b0;
    s = hist[e - 2];
    return s[k];
  endfunction

  // Advance the model by one clock edge.
  task automatic model_edge();
    logic [2:0] pr;
    logic [2:0] new_pl;
    logic       nl;
    logic       flip;
    int         n;
    pr = ~raw_keys;
    n  = hist.size();

    // Outputs registered at this edge come from the pre-edge levels.
    nl = m_pl[1] ? 1'b1 : (m_pl[0] ? 1'b0 : m_last_right);
    e_bl_a = !m_gr && m_st[0] && (!m_st[1] || !nl);
    e_br_a = !m_gr && m_st[1] && (!m_st[0] || nl);
    e_bl_b = !m_gr && m_st[0] && !m_st[1];
    e_br_b = !m_gr && m_st[1] && !m_st[0];
    e_lp   = !m_gr && m_pl[0];
    e_rp   = !m_gr && m_pl[1];
    m_last_right = nl;

    // game_rst stays high until RH quiet edges follow the last trigger.
    if (m_pl[2]) m_hold = RH;
    else if (m_hold > 0) m_hold--;
    m_gr = (m_hold > 0);
    e_gr = m_gr;

    // Stable flips when the last DC synchronised samples all disagree with it.
    new_pl = '0;
    for (int k = 0; k < 3; k++) begin
      flip = 1'b1;
      for (int j = 0; j < int'(DC); j++) begin
        if (sync_at(n - j, k) == m_st[k]) flip = 1'b0;
      end
      if (flip) begin
        new_pl[k] = !m_st[k];
        m_st[k]   = !m_st[k];
      end
    end
    m_pl = new_pl;
    hist.push_back(pr);
  endtask

  task automatic check_all();
    cmp_bit("button_left_a", bl_a, e_bl_a);
    cmp_bit("button_right_a", br_a, e_br_a);
    cmp_bit("left_pressed_a", lp_a, e_lp);
    cmp_bit("right_pressed_a", rp_a, e_rp);
    cmp_bit("game_rst_a", gr_a, e_gr);
    cmp_bit("button_left_b", bl_b, e_bl_b);
    cmp_bit("button_right_b", br_b, e_br_b);
    cmp_bit("left_pressed_b", lp_b, e_lp);
    cmp_bit("right_pressed_b", rp_b, e_rp);
    cmp_bit("game_rst_b", gr_b, e_gr);
  endtask

  // One clock: edge, model step, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (cycles) cycle();
    rst = 1'b1;
  endtask

  int   first;
  int   cnt;
  int   fall_i;
  logic prev;
  logic seen;
  logic cap;
  int   cd[3];

  initial begin
    rst = 1'b0;
    raw_keys = 3'b111;
    model_reset();

    // Reset release: game_rst high for exactly RH edges, outputs quiet.
    @(posedge clk); #1;
    do_reset(3);
    repeat (3) cycle();
    cmp_bit("lit_game_rst_edge3", gr_a, 1'b1);
    cycle();
    cmp_bit("lit_game_rst_edge4", gr_a, 1'b0);
    repeat (6) cycle();

    // Left press: level and single pulse appear 11 cycles after the change.
    raw_keys[0] = 1'b0;
    first = -1; cnt = 0; cap = 1'b0; seen = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first < 0 && bl_a) begin first = i; cap = lp_a; end
      if (lp_a) cnt++;
      if (br_a) seen = 1'b1;
    end
    cmp_int("lit_left_latency", first, 11);
    cmp_bit("lit_left_pulse_with_level", cap, 1'b1);
    cmp_int("lit_left_pulse_width", cnt, 1);
    cmp_bit("lit_right_idle", seen, 1'b0);

    // Bounce every 3 cycles: never long enough to register.
    raw_keys[0] = 1'b1;
    repeat (15) cycle();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) raw_keys[0] = ~raw_keys[0];
      cycle();
      if (bl_a || lp_a) seen = 1'b1;
    end
    raw_keys[0] = 1'b1;
    repeat (15) begin
      cycle();
      if (bl_a || lp_a) seen = 1'b1;
    end
    cmp_bit("lit_bounce_rejected", seen, 1'b0);

    // Left held, right pressed later: handover on the same cycle; b masks both.
    raw_keys[0] = 1'b0;
    repeat (20) cycle();
    raw_keys[1] = 1'b0;
    first = -1; prev = bl_a; cap = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first < 0 && br_a) begin
        first = i;
        cap = prev;
        cmp_bit("lit_handover_left_falls", bl_a, 1'b0);
        cmp_bit("lit_masked_b_left", bl_b, 1'b0);
        cmp_bit("lit_masked_b_right", br_b, 1'b0);
      end
      prev = bl_a;
    end
    cmp_int("lit_right_latency", first, 11);
    cmp_bit("lit_left_before_handover", cap, 1'b1);
    raw_keys[1] = 1'b1;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first < 0 && bl_a) first = i;
    end
    cmp_int("lit_left_back_after_right_release", first, 11);

    // Restart with left held: 4-cycle game_rst, left level returns without a pulse.
    raw_keys[2] = 1'b0;
    cnt = 0; fall_i = -1; prev = gr_a; seen = 1'b0; cap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 16) raw_keys[2] = 1'b1;
      cycle();
      if (gr_a) cnt++;
      if (lp_a) seen = 1'b1;
      if (prev && !gr_a) fall_i = i;
      if (fall_i > 0 && i == fall_i + 1) cap = bl_a;
      prev = gr_a;
    end
    cmp_int("lit_restart_hold_len", cnt, int'(RH));
    cmp_bit("lit_no_pulse_through_reset", seen, 1'b0);
    cmp_bit("lit_left_after_game_rst", cap, 1'b1);

    // Board reset mid-debounce discards the partial count.
    raw_keys[0] = 1'b1;
    repeat (20) cycle();
    raw_keys[0] = 1'b0;
    repeat (7) cycle();
    cmp_int("lit_count_before_reset", int'(dut_a.u_deb_left.r_cnt), 5);
    rst = 1'b0;
    model_reset();
    #1;
    cmp_int("lit_count_after_reset", int'(dut_a.u_deb_left.r_cnt), 0);
    cmp_bit("lit_game_rst_immediate", gr_a, 1'b1);
    check_all();
    repeat (2) cycle();
    rst = 1'b1;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first < 0 && bl_a) first = i;
    end
    cmp_int("lit_full_debounce_after_reset", first, 11);

    // Randomised phase: independent key dwell times with occasional board resets.
    raw_keys = 3'b111;
    cd[0] = 0; cd[1] = 5; cd[2] = 100;
    for (int t = 0; t < 4000; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (cd[k] == 0) begin
          raw_keys[k] = ~raw_keys[k];
          if (k == 2) cd[k] = raw_keys[k] ? int'($urandom_range(60, 300))
                                          : int'($urandom_range(2, 14));
          else        cd[k] = int'($urandom_range(1, 20));
        end else begin
          cd[k]--;
        end
      end
      if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 3)));
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Board-input front end sitting directly upstream of the game top.
- Converts the raw asynchronous push-buttons (left, right, restart) into clean, synchronised, debounced signals and produces the synchronous active-high rst that the game top and all its sub-blocks consume.
- Also resolves simultaneous left+right presses, so control never sees a conflicting direction pair.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips. 10 ms at 50 MHz. Must be ≥ 2.
- RESET_HOLD_CYCLES, 16: cycles game_rst stays high after the reset source is released. Must be ≥ 1.
- KEYS_ACTIVE_LOW, 1: 1 means raw key pins read 0 when pressed.
- LAST_PRESSED_WINS, 1: 1 means that with both directions held, only the most recently pressed one is reported; 0 means both are masked.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low board reset.
- key_left_raw  in  1  raw left key pin.
- key_right_raw  in  1  raw right key pin.
- key_restart_raw  in  1  raw restart key pin.
- button_left  out  1  debounced, conflict-resolved left level; feeds game button_left.
- button_right  out  1  debounced, conflict-resolved right level; feeds game button_right.
- left_pressed  out  1  one-cycle pulse on debounced left press.
- right_pressed  out  1  one-cycle pulse on debounced right press.
- game_rst  out  1  synchronous active-high reset to the game top.

Behaviour:
- Reset (rst=0, asynchronous):
  - All flops clear; synchroniser and stable registers load the released level.
  - Debounce counters are 0.
  - button_left, button_right, left_pressed, right_pressed are 0.
  - game_rst is 1.
- Polarity: each raw pin is inverted when KEYS_ACTIVE_LOW=1, so internal "pressed" is always 1.
- Synchroniser: 2-flop per key; sync2 is the synchronised value.
- Debouncer, per key:
  - Holds a stable bit and a counter of width $clog2(DEBOUNCE_CYCLES).
  - If sync2 == stable, the counter clears.
  - Otherwise the counter increments. When it is at DEBOUNCE_CYCLES-1 and the mismatch persists, stable toggles on the next edge and the counter clears.
  - Any single-cycle return to stable restarts the count (glitch rejection).
  - Latency: raw change sampled at edge k gives stable toggling at edge k+2+DEBOUNCE_CYCLES-1.
  - Press pulse: high exactly the one cycle after stable goes 0→1. Release produces no pulse.
- Direction arbitration (registered, 1 cycle after stable):
  - Only one direction held: that output = 1.
  - Both held, LAST_PRESSED_WINS=1: a last_dir register (updated on each press pulse) selects the output.
  - Same-cycle presses: right wins; last_dir := right.
  - Both held, LAST_PRESSED_WINS=0: both outputs 0.
  - Releasing the winner while the other is still held hands the output to the other on the next cycle.
- Reset sequencer, FSM states HOLD and RUN:
  - HOLD: game_rst=1, down-counter loaded with RESET_HOLD_CYCLES-1; moves to RUN when the counter reaches 0.
  - Entry to HOLD: async reset, or a debounced restart press pulse while in RUN.
  - RUN: game_rst=0.
  - game_rst deassertion is always synchronous to clk.
  - A restart press while already in HOLD reloads the counter.
  - Restart held for a long time does not re-trigger; only a new press does.
- Masking while game_rst=1:
  - button_left/right and the press pulses are forced to 0.
  - Debouncers and last_dir keep running, so a key held through reset appears as a level 1 cycle after game_rst falls, with no press pulse.
- Reset mid-operation: async rst low during a partial debounce count discards it; outputs return to reset values within the same cycle.

Decomposition:
- Shared package game_input_pkg:
  - key index enum KEY_LEFT/KEY_RIGHT/KEY_RESTART.
  - reset-sequencer state enum HOLD/RUN.
  - default DEBOUNCE_CYCLES localparam derived from the CLK parameter shared with the game top.
- Sub-module key_debouncer (synchroniser, debounce counter, stable bit, press pulse), instantiated three times. Arbitration and reset sequencer live in the top of this block.

Test Plan (sim with DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, active-low keys):
- rst low for 3 cycles, then high → game_rst=1 until 4 clk edges after release, then 0; all button outputs 0 throughout.
- key_left_raw=0 held from edge 10 → button_left=1 and left_pressed pulse of 1 cycle at edge 10+2+7+1 (arbitration stage); button_right=0.
- key_left_raw bounces 0/1 every 3 cycles for 30 cycles, then settles at 1 → button_left never asserts; counter observed resetting.
- Left held, right pressed 20 cycles later → button_left falls and button_right rises on the same cycle. Release right → button_left=1 again one cycle after right's stable drops. Repeat with LAST_PRESSED_WINS=0 → both 0 while both held.
- Restart pressed in RUN → game_rst high for 4 cycles; left held across it → button_left=1 the cycle after game_rst falls, with no left_pressed pulse.
- rst asserted mid-debounce (count=5) → counter 0 and game_rst=1 immediately; after release, the full 8-cycle debounce is needed again.
